mult_block_buffer: RTL and testbench
====================================

# mult_block_buffer

Parametrised successor to the 64-entry product buffer. It accepts a stream of operand pairs and multiplies each pair, signed or unsigned. Each result, either the product or a running sum of products, is written to an external single-port-per-direction buffer memory at consecutive addresses. When a block of a run-time-programmable length is full, the buffer is streamed back out under a valid/ready handshake with backpressure. It sits between the operand source and the downstream consumer, and owns the buffer memory's write and read ports.

## Interface
- LOGDEPTH, 6, log2 of memory depth; max block length 2^LOGDEPTH
- IN_WIDTH, 16, operand width
- WIDTH, 32, result/memory word width; must be ≥ 2*IN_WIDTH
- SIGNED, 0, 1 = two's-complement operands, product sign-extended to WIDTH

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_count  in  LOGDEPTH+1  block length; 0 means 2^LOGDEPTH; values > 2^LOGDEPTH clamp to 2^LOGDEPTH
- cfg_accum  in  1  0 = store each product, 1 = store running sum
- EN_mult  in  1  operand pair valid
- RDY_mult  out  1  pair accepted on an edge where EN_mult && RDY_mult
- mult_input0, mult_input1  in  IN_WIDTH each  operands
- EN_writeMem  out  1  memory write strobe
- writeMem_addr  out  LOGDEPTH  write address
- writeMem_val  out  WIDTH  write data
- EN_blockRead  in  1  request readout of a full block
- EN_readMem  out  1  memory read strobe
- readMem_addr  out  LOGDEPTH  read address
- readMem_val  in  WIDTH  read data, valid the cycle after EN_readMem
- VALID_memVal  out  1  memVal_data valid
- memVal_data  out  WIDTH  output word
- memVal_ready  in  1  consumer accepts on an edge where VALID_memVal && memVal_ready
- block_done  out  1  one-cycle pulse after the last word is transferred

## Operation
- States: IDLE, WRITE, FULL, READ. Reset forces IDLE.
- Reset values: RDY_mult=1 (IDLE). All others 0: EN_writeMem, writeMem_addr, writeMem_val, EN_readMem, readMem_addr, VALID_memVal, memVal_data, block_done. Accumulator, counters and 2-entry output FIFO are cleared.
- RDY_mult = 1 in IDLE and WRITE, 0 in FULL and READ.
- IDLE: the first accepted pair latches cfg_count and cfg_accum for the whole block, clears the write index and accumulator, and moves to WRITE. If cfg_count=1, it moves directly to FULL. Config changes mid-block are ignored.
- WRITE: each accept produces one write at index 0,1,2,… When the accept for index N-1 occurs, the state moves to FULL (N = latched length).
- Write data:
  - cfg_accum=0: the product.
  - cfg_accum=1: acc += product, then acc is written.
  - Arithmetic is modulo 2^WIDTH, with sign extension when SIGNED=1.
- FULL: waits for EN_blockRead, then moves to READ. EN_blockRead in any other state is ignored and is not remembered.
- READ:
  - Issues reads at addresses 0..N-1 in order.
  - A read is issued only when FIFO occupancy plus in-flight reads is < 2, so no word is ever dropped.
  - FIFO head drives VALID_memVal/memVal_data.
  - After the N-th transfer: block_done pulses and the state returns to IDLE.
- EN_mult while RDY_mult=0 is ignored; no operand is captured.

## Timing
- Write latency 1:
  - An accept on edge k drives EN_writeMem=1 with addr/val for the cycle after edge k.
  - EN_writeMem is otherwise 0.
  - Back-to-back accepts give back-to-back writes.
- The final write is issued during the first FULL cycle, so it always lands before any read. The earliest EN_blockRead sample is at the end of that cycle.
- The first read is issued in the first READ cycle. The first VALID_memVal occurs 2 cycles after entering READ.
- With memVal_ready held high, one word transfers per cycle. A block of N takes N+2 cycles from READ entry to block_done.
- memVal_data is held stable while VALID_memVal && !memVal_ready.
- block_done is high in the cycle after the last transfer edge. In that same cycle, state is IDLE and RDY_mult=1.
- Asynchronous rst_n assertion at any point, including mid-WRITE or mid-READ, immediately forces reset values. Partial blocks are discarded.
- Address wrap: with N = 2^LOGDEPTH, the last address is 2^LOGDEPTH−1, and the counter does not wrap into a second pass.

## Test plan
- Unsigned store, N=0 (→64), pairs (i, i+1) for i=0..63 streamed continuously → writes at addr i with val i*(i+1). FULL is entered after the 64th accept. Readout with ready=1 yields those 64 values in order, then block_done.
- SIGNED=1, cfg_accum=1, N=4, pairs (−2,3),(4,5),(−1,−1),(0x7FFF,2) → writeMem_val = −6, 14, 15, 65549. Readout returns the same sequence.
- Backpressure: N=8, memVal_ready toggled pseudo-randomly, and held low for 5 cycles mid-stream → exactly 8 transfers, in order, with no duplicates. Data is stable while stalled.
- Boundaries:
  - N=1: one accept → FULL. RDY_mult=0 in the cycle after the accept.
  - EN_blockRead pulsed during WRITE → ignored. EN_mult held high in FULL/READ → no writes.
- rst_n pulsed low mid-READ (after 3 of 8 transfers) → outputs go to reset values asynchronously and the state is IDLE. A fresh block of N=2 then runs correctly.
- Config latch: cfg_count changed from 4 to 10 after the first accept → block still ends after 4 writes.

Source files
------------

// File: rtl/mult_block_buffer.sv
// Operand-pair multiplier that fills a block of an external buffer memory
// with products (or running sums) and then streams the block out under valid/ready.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for the first pair of a block; latches block config
//   S_WRITE | accepting pairs, one memory write per accepted pair
//   S_FULL  | block complete, waiting for EN_blockRead
//   S_READ  | issuing reads through the 2-entry FIFO until N words transfer
module mult_block_buffer #(
  parameter int LOGDEPTH = 6,
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32,
  parameter int SIGNED   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LOGDEPTH:0]     cfg_count,
  input  logic                  cfg_accum,
  input  logic                  EN_mult,
  output logic                  RDY_mult,
  input  logic [IN_WIDTH-1:0]   mult_input0,
  input  logic [IN_WIDTH-1:0]   mult_input1,
  output logic                  EN_writeMem,
  output logic [LOGDEPTH-1:0]   writeMem_addr,
  output logic [WIDTH-1:0]      writeMem_val,
  input  logic                  EN_blockRead,
  output logic                  EN_readMem,
  output logic [LOGDEPTH-1:0]   readMem_addr,
  input  logic [WIDTH-1:0]      readMem_val,
  output logic                  VALID_memVal,
  output logic [WIDTH-1:0]      memVal_data,
  input  logic                  memVal_ready,
  output logic                  block_done
);

  localparam int CW = LOGDEPTH + 1;
  localparam int PW = 2 * IN_WIDTH;
  localparam logic [CW-1:0] MAX_N = {1'b1, {LOGDEPTH{1'b0}}};
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL, S_READ} state_t;

  state_t state_q, state_d;

  logic              accept, first, issue, pop, push;
  logic [CW-1:0]     cfg_n;
  logic [CW-1:0]     n_q, n_d;
  logic              accum_q, accum_d;
  logic [CW-1:0]     widx_q, widx_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              wen_q, wen_d;
  logic [LOGDEPTH-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wval_q, wval_d;
  logic [CW-1:0]     ridx_q, ridx_d;
  logic [CW-1:0]     xfer_q, xfer_d;
  logic              done_q, done_d;
  logic [CW-1:0]     wr_idx;
  logic              wr_mode;
  logic [WIDTH-1:0]  acc_sum;
  logic [PW-1:0]     op0_x, op1_x, prod_n;
  logic [WIDTH-1:0]  prod_w;
  logic [WIDTH-1:0]  fifo_q [2];
  logic              fifo_wp_q, fifo_rp_q;
  logic [1:0]        fifo_cnt_q;
  logic [1:0]        occ;
  logic              inflight_q;

  // Operands are widened first so the low PW bits of the product are exact
  // for both signed and unsigned interpretation.
  always_comb begin
    if (SIGNED != 0) begin
      op0_x = {{IN_WIDTH{mult_input0[IN_WIDTH-1]}}, mult_input0};
      op1_x = {{IN_WIDTH{mult_input1[IN_WIDTH-1]}}, mult_input1};
    end else begin
      op0_x = {{IN_WIDTH{1'b0}}, mult_input0};
      op1_x = {{IN_WIDTH{1'b0}}, mult_input1};
    end
    prod_n = op0_x * op1_x;
  end

  if (WIDTH > PW) begin : g_ext
    assign prod_w = {{(WIDTH-PW){(SIGNED != 0) ? prod_n[PW-1] : 1'b0}}, prod_n};
  end else begin : g_noext
    assign prod_w = prod_n[WIDTH-1:0];
  end

  assign cfg_n  = (cfg_count == '0 || cfg_count > MAX_N) ? MAX_N : cfg_count;
  assign accept = EN_mult && RDY_mult;
  assign first  = (state_q == S_IDLE);

  assign VALID_memVal = (fifo_cnt_q != 2'd0);
  assign memVal_data  = VALID_memVal ? fifo_q[fifo_rp_q] : '0;
  assign pop          = VALID_memVal && memVal_ready;
  assign push         = inflight_q;
  // Occupancy after this cycle's pop, counting the read already in flight.
  assign occ          = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue        = (state_q == S_READ) && (ridx_q < n_q) && (occ < 2'd2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (cfg_n == ONE) ? S_FULL : S_WRITE;
      S_WRITE: if (accept && widx_q == n_q - ONE) state_d = S_FULL;
      S_FULL:  if (EN_blockRead) state_d = S_READ;
      S_READ:  if (pop && xfer_q == n_q - ONE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    RDY_mult     = (state_q == S_IDLE) || (state_q == S_WRITE);
    EN_readMem   = issue;
    readMem_addr = issue ? ridx_q[LOGDEPTH-1:0] : '0;
  end

  assign wr_idx  = first ? '0 : widx_q;
  assign wr_mode = first ? cfg_accum : accum_q;
  assign acc_sum = (first ? '0 : acc_q) + prod_w;

  always_comb begin
    n_d     = n_q;
    accum_d = accum_q;
    widx_d  = widx_q;
    acc_d   = acc_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    if (accept) begin
      if (first) begin
        n_d     = cfg_n;
        accum_d = cfg_accum;
      end
      widx_d  = wr_idx + ONE;
      acc_d   = acc_sum;
      wen_d   = 1'b1;
      waddr_d = wr_idx[LOGDEPTH-1:0];
      wval_d  = wr_mode ? acc_sum : prod_w;
    end
  end

  always_comb begin
    ridx_d = ridx_q;
    xfer_d = xfer_q;
    done_d = 1'b0;
    if (state_q == S_FULL && EN_blockRead) begin
      ridx_d = '0;
      xfer_d = '0;
    end
    if (issue) ridx_d = ridx_q + ONE;
    if (pop) begin
      xfer_d = xfer_q + ONE;
      if (xfer_q == n_q - ONE) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= '0;
      accum_q    <= 1'b0;
      widx_q     <= '0;
      acc_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wval_q     <= '0;
      ridx_q     <= '0;
      xfer_q     <= '0;
      done_q     <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      n_q        <= n_d;
      accum_q    <= accum_d;
      widx_q     <= widx_d;
      acc_q      <= acc_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wval_q     <= wval_d;
      ridx_q     <= ridx_d;
      xfer_q     <= xfer_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (push) begin
        fifo_q[fifo_wp_q] <= readMem_val;
        fifo_wp_q         <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign EN_writeMem   = wen_q;
  assign writeMem_addr = waddr_q;
  assign writeMem_val  = wval_q;
  assign block_done    = done_q;

endmodule

// File: tb/tb_mult_block_buffer.sv
// Bench for mult_block_buffer: an unsigned and a signed instance share stimulus,
// each backed by its own buffer memory and checked against an arithmetic model.
module tb_mult_block_buffer;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] cfg_count;
  logic cfg_accum, EN_mult, EN_blockRead, memVal_ready;
  logic [15:0] mult_input0, mult_input1;
  logic [1:0] rdy, wen, ren, valid, done;
  logic [1:0][5:0] waddr, raddr;
  logic [1:0][31:0] wval, rdata, mdata;
  logic [31:0] mem [2][64];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_s;
  } vec_t;
  vec_t tbl [4];

  logic [15:0] opa [64];
  logic [15:0] opb [64];
  logic [31:0] expv [2][64];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mult_block_buffer #(.LOGDEPTH(6), .IN_WIDTH(16), .WIDTH(32), .SIGNED(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .cfg_count(cfg_count), .cfg_accum(cfg_accum),
    .EN_mult(EN_mult), .RDY_mult(rdy[0]), .mult_input0(mult_input0), .mult_input1(mult_input1),
    .EN_writeMem(wen[0]), .writeMem_addr(waddr[0]), .writeMem_val(wval[0]),
    .EN_blockRead(EN_blockRead), .EN_readMem(ren[0]), .readMem_addr(raddr[0]),
    .readMem_val(rdata[0]), .VALID_memVal(valid[0]), .memVal_data(mdata[0]),
    .memVal_ready(memVal_ready), .block_done(done[0]));

  mult_block_buffer #(.LOGDEPTH(6), .IN_WIDTH(16), .WIDTH(32), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .cfg_count(cfg_count), .cfg_accum(cfg_accum),
    .EN_mult(EN_mult), .RDY_mult(rdy[1]), .mult_input0(mult_input0), .mult_input1(mult_input1),
    .EN_writeMem(wen[1]), .writeMem_addr(waddr[1]), .writeMem_val(wval[1]),
    .EN_blockRead(EN_blockRead), .EN_readMem(ren[1]), .readMem_addr(raddr[1]),
    .readMem_val(rdata[1]), .VALID_memVal(valid[1]), .memVal_data(mdata[1]),
    .memVal_ready(memVal_ready), .block_done(done[1]));

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) mem[k][waddr[k]] <= wval[k];
      if (ren[k]) rdata[k] <= mem[k][raddr[k]];
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_prod(int k, logic [15:0] a, logic [15:0] b);
    longint p;
    if (k == 1) p = longint'($signed(a)) * longint'($signed(b));
    else        p = longint'({16'h0, a}) * longint'({16'h0, b});
    return p[31:0];
  endfunction

  function automatic int eff_n(int cfg);
    return (cfg == 0 || cfg > 64) ? 64 : cfg;
  endfunction

  function automatic void build_exp(int n, bit accum);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] acc = 32'h0;
      for (int i = 0; i < n; i++) begin
        logic [31:0] p = ref_prod(k, opa[i], opb[i]);
        acc = acc + p;
        expv[k][i] = accum ? acc : p;
      end
    end
  endfunction

  task automatic rand_ops(int n);
    for (int i = 0; i < n; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
    end
  endtask

  task automatic chk_reset(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_rdy"}, k, 32'(rdy[k]), 32'd1);
      chk({nm, "_ctl"}, k, 32'({wen[k], ren[k], valid[k], done[k], waddr[k], raddr[k]}), 32'd0);
      chk({nm, "_wval"}, k, wval[k], 32'd0);
      chk({nm, "_data"}, k, mdata[k], 32'd0);
    end
  endtask

  // Streams n pairs; cfg is applied on the first accept, cfg_after afterwards.
  task automatic write_block(int cfg, int cfg_after, bit accum, bit gaps, bit poke);
    int n = eff_n(cfg);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        EN_mult = 1'b0;
        mult_input0 = 16'($urandom);
        EN_blockRead = poke;
        step();
        for (int k = 0; k < 2; k++) chk("wr_gap", k, 32'(wen[k]), 32'd0);
      end
      EN_mult = 1'b1;
      mult_input0 = opa[i];
      mult_input1 = opb[i];
      cfg_count = (i == 0) ? 7'(cfg) : 7'(cfg_after);
      cfg_accum = (i == 0) ? accum : !accum;
      EN_blockRead = poke;
      #1;
      for (int k = 0; k < 2; k++) chk("rdy_write", k, 32'(rdy[k]), 32'd1);
      step();
      for (int k = 0; k < 2; k++) begin
        chk("wr_en", k, 32'(wen[k]), 32'd1);
        chk("wr_addr", k, 32'(waddr[k]), i);
        chk("wr_val", k, wval[k], expv[k][i]);
      end
    end
    EN_blockRead = 1'b0;
    mult_input0 = 16'($urandom);
    #1;
    for (int k = 0; k < 2; k++) chk("rdy_full", k, 32'(rdy[k]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      mult_input1 = 16'($urandom);
      #1;
      for (int k = 0; k < 2; k++) chk("full_quiet", k, 32'({wen[k], ren[k], valid[k]}), 32'd0);
    end
  endtask

  // Reads the block out; bp=1 randomises ready with a forced 5-cycle stall.
  // rst_at>=0 pulses reset once that many words have transferred.
  task automatic read_block(int n, bit bp, int rst_at);
    int xf[2] = '{0, 0};
    int fv[2] = '{-1, -1};
    bit stall[2] = '{0, 0};
    logic [31:0] held[2];
    bit spur = 0;
    int c = 0;
    int bound = 6 * n + 40;
    logic r;
    EN_blockRead = 1'b1;
    step();
    EN_blockRead = 1'b0;
    while ((xf[0] < n || xf[1] < n) && c < bound) begin
      if (rst_at >= 0 && xf[0] == rst_at) break;
      r = bp ? ((c >= 6 && c < 11) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
      memVal_ready = r;
      #1;
      for (int k = 0; k < 2; k++) begin
        if (c == 0) begin
          chk("rd_first_en", k, 32'(ren[k]), 32'd1);
          chk("rd_first_addr", k, 32'(raddr[k]), 32'd0);
        end
        if (wen[k] || done[k]) spur = 1;
        if (stall[k]) begin
          chk("hold_valid", k, 32'(valid[k]), 32'd1);
          chk("hold_data", k, mdata[k], held[k]);
        end
        if (valid[k] && fv[k] < 0) fv[k] = c;
        if (valid[k] && r) begin
          if (xf[k] < n) chk("rd_data", k, mdata[k], expv[k][xf[k]]);
          else spur = 1;
          xf[k]++;
        end
        stall[k] = valid[k] && !r;
        held[k] = mdata[k];
      end
      step();
      c++;
    end
    EN_mult = 1'b0;
    if (rst_at >= 0) begin
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      step();
      step();
      rst_n = 1'b1;
      step();
      return;
    end
    if (c >= bound) begin
      total++;
      bad++;
      $display("FAIL rd_timeout transfers=%0d/%0d required=%0d", xf[0], xf[1], n);
    end
    #1;
    chk("rd_spurious", 0, 32'(spur), 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("done", k, 32'(done[k]), 32'd1);
      chk("rdy_idle", k, 32'(rdy[k]), 32'd1);
      if (!bp) begin
        chk("rd_latency", k, c, n + 2);
        chk("first_valid", k, fv[k], 32'd2);
      end
    end
    step();
    for (int k = 0; k < 2; k++) chk("done_pulse", k, 32'(done[k]), 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'hFFFE, 16'd3, 32'hFFFF_FFFA};
    tbl[1] = '{16'd4, 16'd5, 32'd14};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 32'd15};
    tbl[3] = '{16'h7FFF, 16'd2, 32'd65549};

    rst_n = 1'b0;
    cfg_count = 7'd0;
    cfg_accum = 1'b0;
    EN_mult = 1'b0;
    EN_blockRead = 1'b0;
    memVal_ready = 1'b0;
    mult_input0 = 16'd0;
    mult_input1 = 16'd0;
    #12;
    chk_reset("rst_init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // full 64-entry unsigned store
    for (int i = 0; i < 64; i++) begin
      opa[i] = 16'(i);
      opb[i] = 16'(i + 1);
    end
    build_exp(64, 1'b0);
    write_block(0, 0, 1'b0, 1'b0, 1'b0);
    read_block(64, 1'b0, -1);

    // signed running sum from the vector table
    for (int i = 0; i < 4; i++) begin
      opa[i] = tbl[i].a;
      opb[i] = tbl[i].b;
    end
    build_exp(4, 1'b1);
    for (int i = 0; i < 4; i++) expv[1][i] = tbl[i].exp_s;
    write_block(4, 4, 1'b1, 1'b0, 1'b0);
    read_block(4, 1'b0, -1);

    // backpressure
    rand_ops(8);
    build_exp(8, 1'b0);
    write_block(8, 8, 1'b0, 1'b0, 1'b0);
    read_block(8, 1'b1, -1);

    // single-entry block, blockRead poked while idle
    rand_ops(1);
    build_exp(1, 1'b1);
    write_block(1, 1, 1'b1, 1'b0, 1'b1);
    read_block(1, 1'b0, -1);

    // blockRead poked during WRITE with input gaps
    rand_ops(5);
    build_exp(5, 1'b0);
    write_block(5, 5, 1'b0, 1'b1, 1'b1);
    read_block(5, 1'b1, -1);

    // config changed after the first accept
    rand_ops(4);
    build_exp(4, 1'b1);
    write_block(4, 10, 1'b1, 1'b0, 1'b0);
    read_block(4, 1'b0, -1);

    // oversize count clamps to 64
    rand_ops(64);
    build_exp(64, 1'b1);
    write_block(70, 70, 1'b1, 1'b1, 1'b0);
    read_block(64, 1'b1, -1);

    // reset mid-read, then a fresh 2-entry block
    rand_ops(8);
    build_exp(8, 1'b0);
    write_block(8, 8, 1'b0, 1'b0, 1'b0);
    read_block(8, 1'b0, 3);
    rand_ops(2);
    build_exp(2, 1'b1);
    write_block(2, 2, 1'b1, 1'b0, 1'b0);
    read_block(2, 1'b0, -1);

    // randomised blocks
    for (int b = 0; b < 4; b++) begin
      int cfg = $urandom_range(0, 127);
      bit acc = 1'($urandom_range(0, 1));
      rand_ops(eff_n(cfg));
      build_exp(eff_n(cfg), acc);
      write_block(cfg, $urandom_range(0, 127), acc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      read_block(eff_n(cfg), 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
